// File: rtl/alu_unit.sv
// 8-bit multi-cycle ALU stage: captures operands on start, strobes done with registered result/flags.
// Optional shift-add multiplier is built only when ALU_MUL_EN is defined.
module alu_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] result_hi,
  output logic       zero,
  output logic       carry
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
`endif

  state_t     r_state;
  logic [2:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_result;
  logic [7:0] r_resultHi;
  logic       r_zero;
  logic       r_carry;

  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_res;
  logic       w_cy;

`ifdef ALU_MUL_EN
  logic [3:0]  r_count;
  logic [15:0] r_acc;
  logic [7:0]  r_mplr;
  logic [8:0]  w_upper;
  logic [15:0] w_accNext;

  // One shift-add step: the 9-bit upper sum keeps the add carry as it shifts in.
  always_comb begin
    w_upper   = {1'b0, r_acc[15:8]} + (r_mplr[0] ? {1'b0, r_a} : 9'd0);
    w_accNext = {w_upper, r_acc[7:1]};
  end
`endif

  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_diff = {1'b0, r_a} - {1'b0, r_b};
    w_res  = 8'h00;
    w_cy   = 1'b0;
    case (r_op)
      3'b000: begin w_res = w_sum[7:0];  w_cy = w_sum[8];  end
      3'b001: begin w_res = w_diff[7:0]; w_cy = w_diff[8]; end
      3'b010: w_res = r_a & r_b;
      3'b011: w_res = r_a | r_b;
      3'b100: w_res = r_a ^ r_b;
      3'b101: begin w_res = {r_a[6:0], 1'b0}; w_cy = r_a[7]; end
      3'b110: begin w_res = {1'b0, r_a[7:1]}; w_cy = r_a[0]; end
      default: begin w_res = 8'h00; w_cy = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= 3'd0;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 8'h00;
      r_resultHi <= 8'h00;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
`ifdef ALU_MUL_EN
      r_count    <= 4'd0;
      r_acc      <= 16'h0000;
      r_mplr     <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE accepts a new request exactly like IDLE for back-to-back issue.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_op   <= op;
            r_a    <= inA;
            r_b    <= inB;
            r_busy <= 1'b1;
`ifdef ALU_MUL_EN
            r_count <= 4'd0;
            r_acc   <= 16'h0000;
            r_mplr  <= inB;
            r_state <= (op == 3'b111) ? ST_MUL : ST_EXEC;
`else
            r_state <= ST_EXEC;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_result   <= w_res;
          r_resultHi <= 8'h00;
          r_zero     <= (w_res == 8'h00);
          r_carry    <= w_cy;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_DONE;
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          r_acc   <= w_accNext;
          r_mplr  <= {1'b0, r_mplr[7:1]};
          r_count <= r_count + 4'd1;
          if (r_count == 4'd7) begin
            r_result   <= w_accNext[7:0];
            r_resultHi <= w_accNext[15:8];
            r_zero     <= (w_accNext == 16'h0000);
            r_carry    <= (w_accNext[15:8] != 8'h00);
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_DONE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_resultHi;
  assign zero      = r_zero;
  assign carry     = r_carry;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: driver pushes expected responses, a negedge monitor pops on done.
// Expectations follow ALU_MUL_EN the same way the design build does.
module tb_alu_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] inA = 8'h00;
  logic [7:0] inB = 8'h00;
  logic       busy, done, zero, carry;
  logic [7:0] result, result_hi;

  alu_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  int compared = 0;
  int mismatched = 0;

  // Packed expectation: {result, result_hi, zero, carry}
  typedef struct {
    logic [17:0] val;
    int          acceptCycle;
    int          doneCycle;
  } exp_t;

  exp_t        sbq[$];
  logic [17:0] holdVal = '0;
  int          lastDone = 0;

  function automatic logic [17:0] refModel(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int x, y, r, h, c, p;
    x = int'(a); y = int'(b); r = 0; h = 0; c = 0; p = 0;
    case (o)
      3'd0: begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
      3'd1: begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: begin r = (x * 2) % 256; c = (x >= 128) ? 1 : 0; end
      3'd6: begin r = x / 2; c = x % 2; end
      default: begin
`ifdef ALU_MUL_EN
        p = x * y; r = p % 256; h = p / 256; c = (h != 0) ? 1 : 0;
`endif
      end
    endcase
    return {r[7:0], h[7:0], (r == 0 && h == 0), c[0]};
  endfunction

  function automatic int refLatency(input logic [2:0] o);
`ifdef ALU_MUL_EN
    return (o == 3'd7) ? 8 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got res=%h hi=%h z=%b c=%b, want res=%h hi=%h z=%b c=%b (cycle %0d)",
               name, act[17:10], act[9:2], act[1], act[0], exp[17:10], exp[9:2], exp[1], exp[0], cycleCount);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitUntil(input int target);
    while (cycleCount < target) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; start is sampled at the next edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.val = refModel(o, a, b);
    e.acceptCycle = cycleCount + 1;
    e.doneCycle = e.acceptCycle + refLatency(o);
    sbq.push_back(e);
    lastDone = e.doneCycle;
    start = 1'b1; op = o; inA = a; inB = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); inA = 8'($urandom); inB = 8'($urandom);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    start = 1'b1; op = 3'($urandom); inA = 8'($urandom); inB = 8'($urandom);
    sbq.delete();
    holdVal = '0;
    waitCycles(2);
    rst = 1'b0;
    start = 1'b0;
    checkInt("reset_busy", int'(busy), 0);
    checkInt("reset_done", int'(done), 0);
    checkOutput("reset_outputs", {result, result_hi, zero, carry}, 18'h0);
  endtask

  // Monitor: pops on done, checks latency/values, output hold and busy between strobes.
  always @(negedge clk) begin
    exp_t e;
    logic expBusy;
    if (!rst) begin
      if (done) begin
        if (sbq.size() == 0) begin
          checkInt("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          checkInt("done_latency", cycleCount, e.doneCycle);
          checkOutput("done_result", {result, result_hi, zero, carry}, e.val);
          holdVal = e.val;
        end
      end else begin
        if (sbq.size() > 0 && cycleCount > sbq[0].doneCycle) begin
          checkInt("done_timeout", cycleCount, sbq[0].doneCycle);
          void'(sbq.pop_front());
        end
        checkOutput("hold_outputs", {result, result_hi, zero, carry}, holdVal);
      end
      expBusy = (sbq.size() > 0) && (cycleCount >= sbq[0].acceptCycle) && (cycleCount < sbq[0].doneCycle);
      checkInt("busy", int'(busy), int'(expBusy));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    waitCycles(3);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'($urandom), 8'($urandom), 8'($urandom));
      waitUntil(lastDone + $urandom_range(0, 1));
    end
    applyReset();

    applyStimulus(3'd0, 8'h10, 8'h20);
    waitUntil(lastDone + 1);
    applyStimulus(3'd0, 8'hFF, 8'h01);
    waitUntil(lastDone + 1);
    applyStimulus(3'd1, 8'h05, 8'h07);
    waitUntil(lastDone + 1);
    applyStimulus(3'd5, 8'h81, 8'h00);
    waitUntil(lastDone + 1);
    applyStimulus(3'd6, 8'h81, 8'h00);
    waitUntil(lastDone + 1);

    applyStimulus(3'd7, 8'hFF, 8'hFF);
    waitUntil(lastDone + 1);
    applyStimulus(3'd7, 8'h00, 8'h37);
    waitUntil(lastDone + 1);
    applyStimulus(3'd7, 8'h12, 8'h34);
    waitUntil(lastDone + 1);

    applyStimulus(3'd7, 8'h0C, 8'h0A);
`ifdef ALU_MUL_EN
    waitCycles(2);
    start = 1'b1; op = 3'd0; inA = 8'($urandom); inB = 8'($urandom);
    waitCycles(1);
    start = 1'b0; inA = 8'($urandom);
    waitCycles(2);
    start = 1'b1; op = 3'd4; inA = 8'($urandom);
    waitCycles(1);
    start = 1'b0;
`endif
    waitUntil(lastDone);
    applyStimulus(3'd2, 8'hF0, 8'h3C);
    waitUntil(lastDone + 1);

    applyStimulus(3'd7, 8'hFF, 8'hFF);
    waitCycles(3);
    applyReset();
    applyStimulus(3'd4, 8'hAA, 8'hFF);
    waitUntil(lastDone + 1);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(3'($urandom), 8'($urandom), 8'($urandom));
      gap = $urandom_range(0, 2);
      waitUntil(lastDone + gap);
    end

    waitUntil(lastDone + 3);
    checkInt("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_unit.md
# alu_unit

Multi-cycle 8-bit arithmetic/logic stage sitting directly downstream of the operand registers. It consumes the registered operands `inA`/`inB` on a `start` pulse, executes one of eight operations, and presents a registered result with flags and a one-cycle `done` strobe. Single-cycle ops complete in 1 clock. Multiply, when compiled in, runs an 8-iteration shift-add sequence.

## Interface
- No parameters; datapath fixed at 8 bits, product 16 bits.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  3  opcode, sampled with `start`
- `inA`  in  8  operand A, from operand register, sampled with `start`
- `inB`  in  8  operand B, sampled with `start`
- `busy`  out  1  high while an operation is in flight (EXEC/MUL)
- `done`  out  1  one-cycle strobe: `result`/flags valid and updated this cycle
- `result`  out  8  result low byte
- `result_hi`  out  8  product high byte (MUL only, else 0)
- `zero`  out  1  result (all 16 bits) equals 0
- `carry`  out  1  carry/borrow/shift-out flag

## Operation
- Opcodes:
  - 000 ADD: {carry,result}=inA+inB
  - 001 SUB: result=inA-inB mod 256; carry=1 iff inA<inB (borrow)
  - 010 AND
  - 011 OR
  - 100 XOR: carry=0 for all three logic ops
  - 101 SHL: result=inA<<1, carry=inA[7]
  - 110 SHR: result=inA>>1 logical, carry=inA[0]
  - 111 MUL: {result_hi,result}=inA*inB unsigned; carry=(result_hi!=0)
- `result_hi`=0 for every op except MUL.
- States: IDLE, EXEC, MUL, DONE.
  - IDLE: `busy`=0. `start`=1 captures `op`, `inA`, `inB`. Goes to EXEC, or to MUL if op=111.
  - EXEC: computes the single-cycle result and loads the output registers. Always goes to DONE.
  - MUL: 4-bit counter runs 0..7. Each cycle: if multiplier LSB=1, add multiplicand into the upper half of a 16-bit accumulator (with carry); then shift accumulator and multiplier right. After the count-7 cycle, loads the output registers and goes to DONE.
  - DONE: `done`=1 for exactly this cycle, `busy`=0. `start`=1 here is accepted exactly as in IDLE (back-to-back). Otherwise returns to IDLE.
- `start` while `busy`=1 is ignored; the in-flight op is unaffected.
- Changes on `inA`/`inB`/`op` after capture have no effect.
- `result`, `result_hi`, `zero`, `carry` update only on entry to DONE and hold until the next DONE.
- `rst` (any state, including mid-MUL): state→IDLE, counter and accumulator cleared. All outputs 0: `busy`, `done`, `result`, `result_hi`, `zero`, `carry`. `start` in the reset cycle is ignored.

## Timing
- `start` sampled at edge T0.
- Single-cycle op: EXEC during cycle T0→T1; `done`=1 and outputs valid in cycle T1→T2. Start-to-done latency is 2 edges.
- MUL: MUL state for 8 cycles; `done`=1 in the 9th cycle after T0 (edge T8→T9 window). Latency is 9 edges.
- `busy`=1 from T0+ until DONE is entered.
- Back-to-back throughput: a `start` in DONE gives a new `done` 2 cycles later (single-cycle op) or 9 cycles later (MUL).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ALU_MUL_EN` defined: MUL state and shift-add datapath are built; op 111 behaves as above.
- `ALU_MUL_EN` undefined: MUL state, counter and accumulator are removed. Op 111 takes the EXEC path (latency 2) with `result`=0, `result_hi`=0, `carry`=0, `zero`=1. The port list is unchanged.

## Test plan
- Reset: hold `rst` 2 cycles after random activity -> all outputs 0, `busy`=0. Then ADD 0x10+0x20 -> `done` 2 cycles after start, `result`=0x30, `carry`=0, `zero`=0.
- ADD 0xFF+0x01 -> `result`=0x00, `carry`=1, `zero`=1. SUB 0x05-0x07 -> `result`=0xFE, `carry`=1. SHL 0x81 -> `result`=0x02, `carry`=1. SHR 0x81 -> `result`=0x40, `carry`=1.
- MUL (`ALU_MUL_EN`): 0xFF*0xFF -> `done` exactly 9 cycles after start, `result_hi`=0xFE, `result`=0x01, `carry`=1. Then 0x0C*0x0A -> 0x0078, `carry`=0. Also 0x00*0x37 -> `zero`=1.
- Protocol: `start` pulses while `busy` during MUL, with `inA` changing mid-op -> ignored, product unchanged. `start` in the DONE cycle (AND 0xF0&0x3C) -> accepted, next `done` 2 cycles later, `result`=0x30.
- Reset mid-MUL at cycle 4 -> next cycle `busy`=0, `done` never asserts for that op, outputs 0. A fresh XOR 0xAA^0xFF -> `result`=0x55.
- Build without `ALU_MUL_EN`: op 111 with 0x12, 0x34 -> `done` after 2 cycles, `result`=0, `result_hi`=0, `zero`=1, `carry`=0.
